// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pooling datapath: default element width,
// pooling FSM state encoding and an address-width helper.
package cnn_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } pool_state_t;

    // Index width for an n-entry structure; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for 2x2 max pooling: holds the horizontal pair maxima
// of the even row until the odd row completes each 2x2 window.
// One synchronous write port, one combinational read port.
module pool_line_buf
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8,
    parameter int AW     = addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [AW-1:0]            i_waddr,
    input  logic signed [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]            i_raddr,
    output logic signed [DATA_W-1:0] o_rdata
);

    logic signed [DATA_W-1:0] r_mem [DEPTH];

    // Store one even-row pair maximum per column pair.
    // NOTE: no reset on storage arrays; every entry is written in the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool_stream.sv
// Streaming 2x2 / stride-2 signed max pooling over a raster-order feature map.
// Accepts IMG_W*IMG_H elements per start pulse, emits (IMG_W/2)*(IMG_H/2)
// pooled elements through a single registered output stage, then pulses done.
// Optional build macro: POOL_RELU_EN -- clamps negative pooled results to 0.
module pool_stream
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    input  logic                     out_ready,
    output logic                     done
);

    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = addr_w(LB_DEPTH);
    localparam int COL_W    = addr_w(IMG_W);
    localparam int ROW_W    = addr_w(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    pool_state_t              r_state;
    logic [COL_W-1:0]         r_col;
    logic [ROW_W-1:0]         r_row;
    logic signed [DATA_W-1:0] r_hold;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_done;

    logic                     w_in_fire;
    logic                     w_col_odd;
    logic                     w_row_odd;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_lb_we;
    logic [LB_AW-1:0]         w_lb_addr;
    logic signed [DATA_W-1:0] w_lb_rdata;
    logic signed [DATA_W-1:0] w_pair_max;
    logic signed [DATA_W-1:0] w_quad_max;
    logic signed [DATA_W-1:0] w_result;

    // Input is taken only while running and the output stage can make room.
    assign in_ready   = (r_state == RUN) && (!r_out_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;

    assign w_col_odd  = r_col[0];
    assign w_row_odd  = r_row[0];
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    assign w_lb_addr  = LB_AW'(r_col >> 1);
    assign w_lb_we    = w_in_fire && !w_row_odd && w_col_odd;

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (LB_DEPTH),
        .AW     (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_addr),
        .i_wdata (w_pair_max),
        .i_raddr (w_lb_addr),
        .o_rdata (w_lb_rdata)
    );

    // Window maxima: horizontal pair, then full 2x2 with the buffered row, then optional ReLU.
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        w_pair_max = (in_data > r_hold) ? in_data : r_hold;
        w_quad_max = (w_lb_rdata > w_pair_max) ? w_lb_rdata : w_pair_max;
`ifdef POOL_RELU_EN
        w_result   = w_quad_max[DATA_W-1] ? '0 : w_quad_max;
`else
        w_result   = w_quad_max;
`endif
    end

    // Sequencer: map lifecycle, raster position counters and the done pulse.
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                RUN: begin
                    if (w_in_fire) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row   <= '0;
                                r_state <= FLUSH;
                            end else begin
                                r_row <= r_row + ROW_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (!r_out_valid) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Even-column element of every row, held until its odd-column partner arrives.
    always_ff @(posedge clk) begin
        if (w_in_fire && !w_col_odd) begin
            r_hold <= in_data;
        end
    end

    // Output stage: load on a completed 2x2 window, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_in_fire && w_row_odd && w_col_odd) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = r_done;

endmodule

// File: tb/tb_pool_stream.sv
// Scoreboard bench for pool_stream on a 4x4 map: the driver pushes the
// expected pooled values for each map it sends; a negedge monitor pops and
// compares on every output handshake and watches hold/backpressure/done.
module tb_pool_stream;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;

    typedef int map_t [N];

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_ready;
    logic                 done;

    int n_checks   = 0;
    int n_failures = 0;
    int done_cnt   = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stall first output 5 cycles
    int stall_cnt  = 0;
    int sb[$];

    bit                   stall_pending = 0;
    logic signed [DW-1:0] stall_data    = '0;

    pool_stream #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: max over each 2x2 block in block-raster order, optional ReLU.
    task automatic push_expected(input map_t m);
        for (int br = 0; br < H / 2; br++) begin
            for (int bc = 0; bc < W / 2; bc++) begin
                int mx;
                mx = m[(2 * br) * W + 2 * bc];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (m[(2 * br + dr) * W + 2 * bc + dc] > mx)
                            mx = m[(2 * br + dr) * W + 2 * bc + dc];
`ifdef POOL_RELU_EN
                if (mx < 0) mx = 0;
`endif
                sb.push_back(mx);
            end
        end
    endtask

    // Send the first n_send elements of a map; optional idle gaps and a stray start at restart_at.
    task automatic send_map(input map_t m, input int gap_pct, input int restart_at, input int n_send);
        push_expected(m);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < n_send; i++) begin
            int guard;
            bit acc;
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = m[i];
            if (i == restart_at) start = 1'b1;
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 100) begin
                @(negedge clk);
                acc = in_ready;
                step();
                start = 1'b0;
                guard++;
            end
            if (!acc) begin
                check("in_accept_within_bound", acc, 1);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int guard;
        guard = 0;
        while (done_cnt == d0 && guard < 400) begin
            step();
            guard++;
        end
        check("done_within_bound", (done_cnt != d0), 1);
        repeat (3) step();
        check("done_pulse_count", done_cnt - d0, 1);
        check("sb_drained", sb.size(), 0);
    endtask

    // Downstream ready generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            step();
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 99) < 60);
                2: begin
                    out_ready = 1'b0;
                    if (out_valid) stall_cnt++;
                    if (stall_cnt >= 5) begin
                        out_ready  = 1'b1;
                        ready_mode = 0;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops, output hold while stalled, backpressure, done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_pending) begin
                check("hold_out_valid", out_valid, 1);
                check("hold_out_data", out_data, stall_data);
            end
            if (out_valid && !out_ready)
                check("backpressure_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                check("output_was_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    int exp_v;
                    exp_v = sb.pop_front();
                    check("pooled_value", out_data, exp_v);
                end
            end
            stall_pending = out_valid && !out_ready;
            stall_data    = out_data;
            if (done) begin
                done_cnt++;
                check("sb_empty_at_done", sb.size(), 0);
            end
        end else begin
            stall_pending = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        map_t m;
        int   d0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        repeat (3) step();
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Ramp 0..15 -> 5,7,13,15
        for (int i = 0; i < N; i++) m[i] = i;
        d0 = done_cnt;
        send_map(m, 0, -1, N);
        wait_done(d0);

        // All-negative descending map -8..-23
        for (int i = 0; i < N; i++) m[i] = -8 - i;
        d0 = done_cnt;
        send_map(m, 0, -1, N);
        wait_done(d0);

        // First output stalled for 5 cycles
        for (int i = 0; i < N; i++) m[i] = i;
        stall_cnt  = 0;
        ready_mode = 2;
        d0 = done_cnt;
        send_map(m, 0, -1, N);
        wait_done(d0);

        // Reset after 7 accepted elements, then a fresh full map
        send_map(m, 0, -1, 7);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_done", done, 0);
        step();
        rst_n = 1'b1;
        step();
        d0 = done_cnt;
        send_map(m, 0, -1, N);
        wait_done(d0);

        // in_valid held while idle must not be consumed; stray start mid-run ignored
        in_valid = 1'b1;
        in_data  = 1000;
        repeat (4) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
            step();
        end
        for (int i = 0; i < N; i++) m[i] = 3 * i - 20;
        d0 = done_cnt;
        send_map(m, 0, 8, N);
        wait_done(d0);

        // Randomised maps with input gaps and random downstream stalls
        ready_mode = 1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++)
                m[i] = (k % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 20)) - 10;
            d0 = done_cnt;
            send_map(m, 30, -1, N);
            wait_done(d0);
        end
        ready_mode = 0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/pool_stream.md
POOL_STREAM -- requirements
Module: pool_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32: signed feature-map element width.
REQ-002 SHALL have parameter IMG_W, default 16: input row length in elements, even, >=2.
REQ-003 SHALL have parameter IMG_H, default 16: input rows per map, even, >=2.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse from layer controller (maxp_run) beginning one map.
REQ-007 SHALL have port in_valid  input  1  upstream element valid.
REQ-008 SHALL have port in_data  input  DATA_W  signed element, raster order (row-major).
REQ-009 SHALL have port in_ready  output  1  element accepted when in_valid && in_ready.
REQ-010 SHALL have port out_valid  output  1  pooled element valid.
REQ-011 SHALL have port out_data  output  DATA_W  signed pooled element.
REQ-012 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 SHALL have port done  output  1  one-cycle pulse after last pooled element accepted (feeds maxp_done).

Function
REQ-014 SHALL implement 2x2 max pooling, stride 2, signed compare, emitting (IMG_W/2)*(IMG_H/2) elements in raster order.
REQ-015 SHALL use FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start; RUN->FLUSH on acceptance of element (IMG_H-1, IMG_W-1); FLUSH->DONE when output register empty; DONE->IDLE unconditionally next cycle.
REQ-016 SHALL assert done only in DONE, exactly one cycle.
REQ-017 SHALL ignore start in any state other than IDLE.
REQ-018 SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters, advancing col per accepted element, wrapping to 0 and incrementing row at IMG_W-1.
REQ-019 Even row: even col stores element in hold register; odd col writes max(hold, in_data) into line buffer entry col/2.
REQ-020 Odd row: even col stores hold; odd col loads output register with max(linebuf[col/2], hold, in_data) and sets out_valid next cycle.
REQ-021 SHALL have latency of one cycle from acceptance of the completing element to out_valid.
REQ-022 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready); simultaneous output accept and input accept in one cycle SHALL be supported with no bubble.
REQ-023 SHALL hold out_valid and out_data stable until accepted.
REQ-024 SHALL leave in_ready low in IDLE, FLUSH, DONE; elements presented there are not consumed.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, counters=0, out_valid=0, out_data=0, in_ready=0, done=0.
REQ-026 Reset mid-map SHALL discard all partial results; next start begins a fresh map at (0,0).
REQ-027 Line buffer and hold register SHALL not require reset (always written before read).

Configuration
REQ-028 With POOL_RELU_EN defined, output register load SHALL clamp negative results to 0 (fused ReLU); without it, result passes unmodified; latency unchanged either way.

Structure
REQ-029 Package cnn_pkg SHALL hold DATA_W default constant and pool_state_t enum (IDLE, RUN, FLUSH, DONE).
REQ-030 Line buffer SHALL be sub-module pool_line_buf: IMG_W/2 x DATA_W register array, one write port, one combinational read port.

Verification (IMG_W=4, IMG_H=4)
REQ-031 start, stream 0..15 with out_ready=1 -> outputs 5,7,13,15 in order, then done pulse once.
REQ-032 stream all-negative map -8..-23 descending -> outputs -8,-10,-16,-18; with POOL_RELU_EN -> 0,0,0,0.
REQ-033 out_ready low for 5 cycles at first output -> out_data stays 5, in_ready low after next element, no element lost or duplicated.
REQ-034 rst_n low after 7 inputs accepted, then start and full map 0..15 -> exactly 5,7,13,15, single done.
REQ-035 start pulsed during RUN and in_valid held in IDLE -> no restart, no element consumed before start.
